// File: rtl/cpu7_wbu.sv
// Write-back unit: a one-entry WB register feeding the GPR file, forwarding and debug
// ports, plus the exception redirect handshake. The optional retired-instruction
// counter is built only when CPU7_WBU_RETIRE_CNT_EN is defined.
`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_wbu #(
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [`GRLEN-1:0] ex_pc,
  input  logic              ex_rf_wen,
  input  logic [4:0]        ex_rf_target,
  input  logic [`GRLEN-1:0] ex_rf_wdata,
  input  logic              ex_exception,
  input  logic [5:0]        ex_exccode,
  output logic              ex_ready,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [`GRLEN-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [4:0]        fwd_target,
  output logic [`GRLEN-1:0] fwd_data,
  output logic              flush_req,
  output logic [`GRLEN-1:0] flush_epc,
  output logic [5:0]        flush_exccode,
  input  logic              flush_ack,
  output logic [`GRLEN-1:0] debug0_wb_pc,
  output logic              debug0_wb_rf_wen,
  output logic [4:0]        debug0_wb_rf_wnum,
  output logic [`GRLEN-1:0] debug0_wb_rf_wdata,
  output logic [63:0]       retire_cnt,
  output logic              fsm_state
);

  // Handshake: a result transfers on every rising edge where ex_valid and ex_ready
  // are both 1; ex_ready is 1 whenever reset is low, so the EXU never stalls here.

  typedef enum logic {
    RUN        = 1'b0,
    FLUSH_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t              state, state_next;
  logic [7:0]          wait_cnt, wait_cnt_next;
  logic                flush_req_next;
  logic                accept, load_wb, take_exc;

  logic                wb_valid;
  logic                wb_wen;
  logic [`GRLEN-1:0]   wb_pc;
  logic [4:0]          wb_target;
  logic [`GRLEN-1:0]   wb_wdata;

  assign ex_ready = ~reset;
  assign accept   = ex_valid & ex_ready;
  // Results arriving while a redirect is outstanding are swallowed.
  assign load_wb  = accept & (state == RUN);
  assign take_exc = load_wb & ex_exception;

  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    flush_req_next = 1'b0;
    case (state)
      RUN: begin
        if (take_exc) begin
          state_next     = FLUSH_WAIT;
          wait_cnt_next  = '0;
          flush_req_next = 1'b1;
        end
      end
      FLUSH_WAIT: begin
        // An ack beats a simultaneous timeout: no redundant re-pulse.
        if (flush_ack) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          wait_cnt_next  = '0;
          flush_req_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      flush_req <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      flush_req <= flush_req_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_epc     <= '0;
      flush_exccode <= '0;
    end else if (take_exc) begin
      flush_epc     <= ex_pc;
      flush_exccode <= ex_exccode;
    end
  end

  // The whole WB entry clears when nothing is loaded, so debug and forwarding
  // ports read as zero in idle and discard cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_pc     <= '0;
      wb_target <= '0;
      wb_wdata  <= '0;
    end else if (load_wb) begin
      wb_valid  <= 1'b1;
      wb_wen    <= ex_rf_wen & (ex_rf_target != 5'd0) & ~ex_exception;
      wb_pc     <= ex_pc;
      wb_target <= ex_rf_target;
      wb_wdata  <= ex_rf_wdata;
    end else begin
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_pc     <= '0;
      wb_target <= '0;
      wb_wdata  <= '0;
    end
  end

  assign rf_wen             = wb_valid & wb_wen;
  assign rf_waddr           = wb_target;
  assign rf_wdata           = wb_wdata;
  assign fwd_valid          = wb_valid & wb_wen;
  assign fwd_target         = wb_target;
  assign fwd_data           = wb_wdata;
  assign debug0_wb_pc       = wb_pc;
  assign debug0_wb_rf_wen   = wb_valid & wb_wen;
  assign debug0_wb_rf_wnum  = wb_target;
  assign debug0_wb_rf_wdata = wb_wdata;
  assign fsm_state          = state;

`ifdef CPU7_WBU_RETIRE_CNT_EN
  // Excepting instructions occupy the WB entry too, so they are counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (wb_valid) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu7_wbu.sv
// Directed bench for cpu7_wbu: write-back, r0 suppression, exception redirect,
// timeout re-pulse, reset during flush and the retired-instruction counter.
`ifndef GRLEN
`define GRLEN 32
`endif

module tb_cpu7_wbu;

  logic              clk;
  logic              reset;
  logic              ex_valid;
  logic [`GRLEN-1:0] ex_pc;
  logic              ex_rf_wen;
  logic [4:0]        ex_rf_target;
  logic [`GRLEN-1:0] ex_rf_wdata;
  logic              ex_exception;
  logic [5:0]        ex_exccode;
  logic              ex_ready;
  logic              rf_wen;
  logic [4:0]        rf_waddr;
  logic [`GRLEN-1:0] rf_wdata;
  logic              fwd_valid;
  logic [4:0]        fwd_target;
  logic [`GRLEN-1:0] fwd_data;
  logic              flush_req;
  logic [`GRLEN-1:0] flush_epc;
  logic [5:0]        flush_exccode;
  logic              flush_ack;
  logic [`GRLEN-1:0] debug0_wb_pc;
  logic              debug0_wb_rf_wen;
  logic [4:0]        debug0_wb_rf_wnum;
  logic [`GRLEN-1:0] debug0_wb_rf_wdata;
  logic [63:0]       retire_cnt;
  logic              fsm_state;

  int passed;
  int total;
  int pulses;

  cpu7_wbu #(.FLUSH_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rf_wen(ex_rf_wen),
    .ex_rf_target(ex_rf_target), .ex_rf_wdata(ex_rf_wdata),
    .ex_exception(ex_exception), .ex_exccode(ex_exccode), .ex_ready(ex_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_target(fwd_target), .fwd_data(fwd_data),
    .flush_req(flush_req), .flush_epc(flush_epc), .flush_exccode(flush_exccode),
    .flush_ack(flush_ack),
    .debug0_wb_pc(debug0_wb_pc), .debug0_wb_rf_wen(debug0_wb_rf_wen),
    .debug0_wb_rf_wnum(debug0_wb_rf_wnum), .debug0_wb_rf_wdata(debug0_wb_rf_wdata),
    .retire_cnt(retire_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic [`GRLEN-1:0] pc, input logic wen,
                       input logic [4:0] tgt, input logic [`GRLEN-1:0] data,
                       input logic exc, input logic [5:0] code);
    ex_valid = v; ex_pc = pc; ex_rf_wen = wen; ex_rf_target = tgt;
    ex_rf_wdata = data; ex_exception = exc; ex_exccode = code;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 5'd0, '0, 1'b0, 6'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    flush_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (ex_ready !== 1'b0) $display("FAIL rst_ex_ready got %0h exp 0", ex_ready); else passed++;
    total++; if (rf_wen !== 1'b0) $display("FAIL rst_rf_wen got %0h exp 0", rf_wen); else passed++;
    total++; if (flush_req !== 1'b0) $display("FAIL rst_flush_req got %0h exp 0", flush_req); else passed++;
    total++; if (debug0_wb_pc !== '0) $display("FAIL rst_dbg_pc got %0h exp 0", debug0_wb_pc); else passed++;
    total++; if (retire_cnt !== 64'd0) $display("FAIL rst_retire got %0d exp 0", retire_cnt); else passed++;
    total++; if (fsm_state !== 1'b0) $display("FAIL rst_state got %0h exp 0", fsm_state); else passed++;
    step();
    reset = 1'b0;
    #1;
    total++; if (ex_ready !== 1'b1) $display("FAIL run_ex_ready got %0h exp 1", ex_ready); else passed++;
  endtask

  task automatic test_write();
    drive(1'b1, 32'h1c00_0000, 1'b1, 5'd5, 32'h1234, 1'b0, 6'd0);
    step();
    idle();
    total++; if (rf_wen !== 1'b1) $display("FAIL wr_rf_wen got %0h exp 1", rf_wen); else passed++;
    total++; if (rf_waddr !== 5'd5) $display("FAIL wr_waddr got %0d exp 5", rf_waddr); else passed++;
    total++; if (rf_wdata !== 32'h1234) $display("FAIL wr_wdata got %0h exp 1234", rf_wdata); else passed++;
    total++; if (debug0_wb_pc !== 32'h1c00_0000) $display("FAIL wr_dbg_pc got %0h exp 1c000000", debug0_wb_pc); else passed++;
    total++; if (fwd_valid !== 1'b1 || fwd_target !== 5'd5 || fwd_data !== 32'h1234)
      $display("FAIL wr_fwd got %0h/%0d/%0h exp 1/5/1234", fwd_valid, fwd_target, fwd_data); else passed++;
    step();
    total++; if (rf_wen !== 1'b0) $display("FAIL wr_idle_rf_wen got %0h exp 0", rf_wen); else passed++;
  endtask

  task automatic test_r0();
    drive(1'b1, 32'h1c00_0004, 1'b1, 5'd0, 32'hdead, 1'b0, 6'd0);
    step();
    idle();
    total++; if (rf_wen !== 1'b0) $display("FAIL r0_rf_wen got %0h exp 0", rf_wen); else passed++;
    total++; if (debug0_wb_rf_wen !== 1'b0) $display("FAIL r0_dbg_wen got %0h exp 0", debug0_wb_rf_wen); else passed++;
    total++; if (debug0_wb_pc !== 32'h1c00_0004) $display("FAIL r0_dbg_pc got %0h exp 1c000004", debug0_wb_pc); else passed++;
    total++; if (fwd_valid !== 1'b0) $display("FAIL r0_fwd_valid got %0h exp 0", fwd_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [`GRLEN-1:0] pcs [4];
    logic [`GRLEN-1:0] datas [4];
    logic [4:0] tgts [4];
    logic wens [4];
    logic exp_wen [4];
    pcs   = '{32'h1c00_0100, 32'h1c00_0104, 32'h1c00_0108, 32'h1c00_010c};
    datas = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'hffff_ffff};
    tgts  = '{5'd1, 5'd31, 5'd7, 5'd7};
    wens  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_wen = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i], wens[i], tgts[i], datas[i], 1'b0, 6'd0);
      step();
      total++; if (rf_wen !== exp_wen[i] || debug0_wb_pc !== pcs[i] || debug0_wb_rf_wnum !== tgts[i] || debug0_wb_rf_wdata !== datas[i])
        $display("FAIL b2b_%0d got wen %0h pc %0h n %0d d %0h exp wen %0h pc %0h n %0d d %0h", i, rf_wen, debug0_wb_pc,
                 debug0_wb_rf_wnum, debug0_wb_rf_wdata, exp_wen[i], pcs[i], tgts[i], datas[i]);
      else passed++;
    end
    idle();
    step();
  endtask

  task automatic test_exception_flush();
    pulses = 0;
    drive(1'b1, 32'h1c00_0010, 1'b1, 5'd3, 32'h55, 1'b1, 6'h0b);
    step();
    if (flush_req === 1'b1) pulses++;
    total++; if (debug0_wb_pc !== 32'h1c00_0010) $display("FAIL exc_dbg_pc got %0h exp 1c000010", debug0_wb_pc); else passed++;
    total++; if (debug0_wb_rf_wen !== 1'b0 || rf_wen !== 1'b0) $display("FAIL exc_wen got %0h/%0h exp 0/0", debug0_wb_rf_wen, rf_wen); else passed++;
    total++; if (flush_req !== 1'b1) $display("FAIL exc_flush_req got %0h exp 1", flush_req); else passed++;
    total++; if (flush_epc !== 32'h1c00_0010) $display("FAIL exc_epc got %0h exp 1c000010", flush_epc); else passed++;
    total++; if (flush_exccode !== 6'h0b) $display("FAIL exc_code got %0h exp b", flush_exccode); else passed++;
    total++; if (fsm_state !== 1'b1) $display("FAIL exc_state got %0h exp 1", fsm_state); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c00_0014 + 32'(4 * i), 1'b1, 5'(6 + i), 32'(32'h900 + i), 1'b0, 6'd0);
      flush_ack = (i == 3);
      step();
      if (flush_req === 1'b1) pulses++;
      total++; if (rf_wen !== 1'b0 || debug0_wb_pc !== '0) $display("FAIL exc_discard_%0d got wen %0h pc %0h exp 0/0", i, rf_wen, debug0_wb_pc); else passed++;
    end
    flush_ack = 1'b0;
    total++; if (fsm_state !== 1'b0) $display("FAIL exc_back_run got %0h exp 0", fsm_state); else passed++;
    total++; if (pulses != 1) $display("FAIL exc_pulses got %0d exp 1", pulses); else passed++;
    drive(1'b1, 32'h1c00_0030, 1'b1, 5'd10, 32'habc, 1'b0, 6'd0);
    step();
    idle();
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'habc)
      $display("FAIL exc_after got %0h/%0d/%0h exp 1/10/abc", rf_wen, rf_waddr, rf_wdata); else passed++;
    total++; if (flush_epc !== 32'h1c00_0010 || flush_exccode !== 6'h0b)
      $display("FAIL exc_epc_hold got %0h/%0h exp 1c000010/b", flush_epc, flush_exccode); else passed++;
  endtask

  task automatic test_timeout();
    logic exp_req;
    drive(1'b1, 32'h1c00_0020, 1'b0, 5'd0, '0, 1'b1, 6'h08);
    step();
    idle();
    total++; if (flush_req !== 1'b1) $display("FAIL to_first_pulse got %0h exp 1", flush_req); else passed++;
    total++; if (flush_epc !== 32'h1c00_0020 || flush_exccode !== 6'h08)
      $display("FAIL to_epc got %0h/%0h exp 1c000020/8", flush_epc, flush_exccode); else passed++;
    for (int k = 2; k <= 12; k++) begin
      step();
      exp_req = ((k - 1) % 4 == 0);
      total++; if (flush_req !== exp_req) $display("FAIL to_req_%0d got %0h exp %0h", k, flush_req, exp_req); else passed++;
    end
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    total++; if (flush_req !== 1'b0) $display("FAIL to_ack_wins got %0h exp 0", flush_req); else passed++;
    total++; if (fsm_state !== 1'b0) $display("FAIL to_run got %0h exp 0", fsm_state); else passed++;
  endtask

  task automatic test_ack_in_run();
    flush_ack = 1'b1;
    drive(1'b1, 32'h1c00_0040, 1'b1, 5'd4, 32'h44, 1'b0, 6'd0);
    step();
    idle();
    flush_ack = 1'b0;
    total++; if (fsm_state !== 1'b0 || flush_req !== 1'b0 || rf_wen !== 1'b1)
      $display("FAIL ack_run got st %0h req %0h wen %0h exp 0/0/1", fsm_state, flush_req, rf_wen); else passed++;
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 32'h1c00_0050, 1'b1, 5'd2, 32'h22, 1'b1, 6'h01);
    step();
    idle();
    step();
    #2;
    reset = 1'b1;
    #1;
    total++; if (ex_ready !== 1'b0 || flush_req !== 1'b0 || fsm_state !== 1'b0)
      $display("FAIL rmf_imm got rdy %0h req %0h st %0h exp 0/0/0", ex_ready, flush_req, fsm_state); else passed++;
    total++; if (flush_epc !== '0 || flush_exccode !== 6'd0 || debug0_wb_pc !== '0)
      $display("FAIL rmf_regs got %0h/%0h/%0h exp 0/0/0", flush_epc, flush_exccode, debug0_wb_pc); else passed++;
    drive(1'b1, 32'h1c00_0060, 1'b1, 5'd9, 32'h99, 1'b0, 6'd0);
    step();
    total++; if (rf_wen !== 1'b0) $display("FAIL rmf_hold_wen got %0h exp 0", rf_wen); else passed++;
    idle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (flush_req !== 1'b0 || fsm_state !== 1'b0)
        $display("FAIL rmf_no_pulse_%0d got %0h/%0h exp 0/0", i, flush_req, fsm_state); else passed++;
    end
    drive(1'b1, 32'h1c00_0070, 1'b1, 5'd12, 32'hc0de, 1'b0, 6'd0);
    step();
    idle();
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hc0de)
      $display("FAIL rmf_next got %0h/%0d/%0h exp 1/12/c0de", rf_wen, rf_waddr, rf_wdata); else passed++;
  endtask

  task automatic test_retire_cnt();
    logic [63:0] exp_cnt;
`ifdef CPU7_WBU_RETIRE_CNT_EN
    exp_cnt = 64'd10;
`else
    exp_cnt = 64'd0;
`endif
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1c00_0200 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i), (i == 9), 6'h02);
      step();
    end
    drive(1'b1, 32'h1c00_0300, 1'b1, 5'd3, 32'h3, 1'b0, 6'd0);
    step();
    total++; if (retire_cnt !== exp_cnt) $display("FAIL ret_cnt got %0d exp %0d", retire_cnt, exp_cnt); else passed++;
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    idle();
    step();
    total++; if (retire_cnt !== exp_cnt) $display("FAIL ret_cnt_discard got %0d exp %0d", retire_cnt, exp_cnt); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    flush_ack = 1'b0;
    idle();
    test_reset();
    test_write();
    test_r0();
    test_back_to_back();
    test_exception_flush();
    test_timeout();
    test_ack_in_run();
    test_reset_mid_flush();
    test_retire_cnt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu7_wbu.md
CPU7_WBU -- requirements
Module: cpu7_wbu

Interface
REQ-001 The module SHALL take parameter FLUSH_TIMEOUT, default 16, the number of cycles to wait for flush_ack before flush_req is re-pulsed (legal range 2..255).
REQ-002 The module SHALL size datapaths with `GRLEN from common.vh; no other width parameter is used.
REQ-003 The module SHALL have these ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EXU result valid.
- ex_pc  in  GRLEN  PC of the result.
- ex_rf_wen  in  1  result writes the GPR file.
- ex_rf_target  in  5  destination GPR.
- ex_rf_wdata  in  GRLEN  result data.
- ex_exception  in  1  instruction raised an exception.
- ex_exccode  in  6  exception code.
- ex_ready  out  1  WBU accepts the EXU result this cycle.
- rf_wen  out  1  GPR write enable.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  GRLEN  GPR write data.
- fwd_valid  out  1  WB register holds a forwardable write.
- fwd_target  out  5  forwarding destination.
- fwd_data  out  GRLEN  forwarding data.
- flush_req  out  1  one-cycle redirect request to IFU/EXU.
- flush_epc  out  GRLEN  PC of the excepting instruction.
- flush_exccode  out  6  exception code.
- flush_ack  in  1  IFU has taken the redirect.
- debug0_wb_pc  out  GRLEN  retired PC.
- debug0_wb_rf_wen  out  1  retired write enable.
- debug0_wb_rf_wnum  out  5  retired destination.
- debug0_wb_rf_wdata  out  GRLEN  retired data.
- retire_cnt  out  64  retired-instruction count (see Configuration).

Function
REQ-004 The module SHALL hold one WB register (valid, pc, wen, target, wdata) loaded on every cycle where ex_valid and ex_ready are both 1, and cleared to invalid otherwise.
REQ-005 The module SHALL have latency 1: a result accepted in cycle N appears on rf_* and debug0_* in cycle N+1.
REQ-006 The module SHALL force the stored wen to 0 when ex_rf_target is 0 or ex_exception is 1.
REQ-007 rf_wen, debug0_wb_rf_wen and fwd_valid SHALL equal WB valid AND stored wen; rf_waddr, rf_wdata, fwd_* and debug0_* SHALL mirror the WB register.
REQ-008 The module SHALL implement FSM states RUN and FLUSH_WAIT; ex_ready SHALL be 1 in both states.
REQ-009 In RUN, an accepted result with ex_exception=1 SHALL move the FSM to FLUSH_WAIT, latch ex_pc and ex_exccode into flush_epc and flush_exccode, and assert flush_req for exactly the next cycle.
REQ-010 In FLUSH_WAIT, every ex_valid SHALL be accepted and discarded: no WB load, no retire, no debug output.
REQ-011 In FLUSH_WAIT, flush_ack=1 SHALL return the FSM to RUN on the next cycle; results in that same cycle are still discarded.
REQ-012 In FLUSH_WAIT, a 8-bit wait counter SHALL increment each cycle; on reaching FLUSH_TIMEOUT without an ack, flush_req SHALL re-pulse for one cycle and the counter SHALL clear.
REQ-013 If flush_ack and a timeout occur in the same cycle, ack SHALL win: return to RUN, no re-pulse.
REQ-014 flush_ack in RUN SHALL be ignored.
REQ-015 flush_epc and flush_exccode SHALL hold their value until the next exception is accepted.
REQ-016 The excepting instruction SHALL itself appear on debug0_wb_pc with debug0_wb_rf_wen=0, and SHALL count as retired.

Reset
REQ-017 Asserting reset SHALL immediately set the FSM to RUN, WB valid to 0, flush_req to 0, the wait counter to 0, flush_epc to 0, flush_exccode to 0, and retire_cnt to 0.
REQ-018 While reset is 1, all outputs SHALL be 0 except ex_ready, which SHALL be 0.
REQ-019 Reset asserted during FLUSH_WAIT SHALL abandon the flush with no further flush_req pulse.

Configuration
REQ-020 When macro CPU7_WBU_RETIRE_CNT_EN is defined, retire_cnt SHALL be a 64-bit counter that increments by 1 for each cycle with WB valid=1 and wraps from all-ones to 0.
REQ-021 When CPU7_WBU_RETIRE_CNT_EN is undefined, retire_cnt SHALL be tied to 0 and no counter flops SHALL be instantiated.

Verification
REQ-022 Directed scenario: write r5=0x1234 at pc 0x1c000000 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, debug0_wb_pc=0x1c000000.
REQ-023 Directed scenario: write to r0 with data 0xdead -> rf_wen=0, debug0_wb_rf_wen=0, debug0_wb_pc valid.
REQ-024 Directed scenario: exception at pc 0x1c000010 with exccode 0x0b, followed by three valid results, then flush_ack on the 5th cycle -> one flush_req pulse with flush_epc=0x1c000010 and exccode 0x0b, no rf_wen for the three results, RUN afterwards.
REQ-025 Directed scenario: exception with no ack and FLUSH_TIMEOUT=4 -> flush_req re-pulses every 4 cycles; ack arriving on a timeout cycle -> no pulse.
REQ-026 Directed scenario: reset asserted mid-FLUSH_WAIT -> outputs 0 immediately, RUN after release, the next result written normally.
REQ-027 Directed scenario: with CPU7_WBU_RETIRE_CNT_EN defined, 10 results including 1 exception -> retire_cnt=10; with the macro undefined -> retire_cnt stays 0.
